// File: rtl/joy_stepper_if.sv
// Purpose: bundles the joystick sample stream, the game-rate tick and the
// conditioned lane outputs of joy_stepper into one connection.
// Ports (signals):
//   tick        game-rate strobe (1 clk cycle)
//   pos_valid   strobe: pos_data holds a new sample
//   pos_data    10-bit unsigned joystick X sample
//   plrpos      current lane index
//   step_pulse  1-cycle pulse after plrpos changed
//   step_dir    direction of last step (0 = left, 1 = right)
//   zone        registered zone: 00 neutral, 01 left, 10 right
// Modports: master drives tick/pos_*, slave is the stepper itself.
interface joy_stepper_if;
    logic       tick;
    logic       pos_valid;
    logic [9:0] pos_data;
    logic [3:0] plrpos;
    logic       step_pulse;
    logic       step_dir;
    logic [1:0] zone;

    modport master (
        output tick, pos_valid, pos_data,
        input  plrpos, step_pulse, step_dir, zone
    );

    modport slave (
        input  tick, pos_valid, pos_data,
        output plrpos, step_pulse, step_dir, zone
    );
endinterface

// File: rtl/joy_stepper.sv
// Purpose: turns raw joystick X samples into discrete player lane steps.
// A deadband/hysteresis zone register feeds an auto-repeat FSM (one step on
// deflection, a hold delay, then periodic repeat steps) that moves a
// saturating 4-bit lane index.
// Ports:
//   clk   system clock, rising edge
//   clr   synchronous reset, active-low
//   bus   joy_stepper_if.slave: tick, pos_valid, pos_data in;
//         plrpos, step_pulse, step_dir, zone out
module joy_stepper #(
    parameter int CENTER       = 512,
    parameter int DEADBAND     = 100,
    parameter int HYST         = 16,
    parameter int HOLD_TICKS   = 8,
    parameter int REPEAT_TICKS = 3,
    parameter int PLR_MAX      = 15,
    parameter int PLR_INIT     = 7
) (
    input  logic               clk,
    input  logic               clr,
    joy_stepper_if.slave       bus
);

    typedef enum logic [1:0] {
        ZONE_NEUTRAL = 2'b00,
        ZONE_LEFT    = 2'b01,
        ZONE_RIGHT   = 2'b10
    } zone_t;

    typedef enum logic [1:0] {
        ST_NEUTRAL = 2'd0,
        ST_DELAY   = 2'd1,
        ST_REPEAT  = 2'd2
    } state_t;

    localparam int CNT_MAX = (HOLD_TICKS > REPEAT_TICKS) ? HOLD_TICKS - 1
                                                          : REPEAT_TICKS - 1;
    localparam int CNT_W   = (CNT_MAX < 2) ? 1 : $clog2(CNT_MAX + 1);

    localparam logic [CNT_W-1:0] HOLD_RELOAD   = CNT_W'(HOLD_TICKS - 1);
    localparam logic [CNT_W-1:0] REPEAT_RELOAD = CNT_W'(REPEAT_TICKS - 1);

    // Entry thresholds are strict; exit thresholds sit HYST inside them.
    localparam logic [10:0] LEFT_ENTER  = 11'(CENTER - DEADBAND);
    localparam logic [10:0] RIGHT_ENTER = 11'(CENTER + DEADBAND);
    localparam logic [10:0] LEFT_EXIT   = 11'(CENTER - DEADBAND + HYST);
    localparam logic [10:0] RIGHT_EXIT  = 11'(CENTER + DEADBAND - HYST);

    localparam logic [3:0] PLR_TOP   = 4'(PLR_MAX);
    localparam logic [3:0] PLR_START = 4'(PLR_INIT);

    zone_t            zone_q;
    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             dir_q, dir_d;
    logic             step_req;
    logic             want_dir;
    logic [3:0]       plrpos_q;
    logic             step_pulse_q;
    logic             step_dir_q;
    logic [10:0]      pos_ext;

    assign pos_ext  = {1'b0, bus.pos_data};
    // Direction requested by the current zone: 1 = right.
    assign want_dir = (zone_q == ZONE_RIGHT);

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        dir_d    = dir_q;
        step_req = 1'b0;
        if (bus.tick) begin
            case (state_q)
                ST_NEUTRAL: begin
                    if (zone_q != ZONE_NEUTRAL) begin
                        step_req = 1'b1;
                        dir_d    = want_dir;
                        cnt_d    = HOLD_RELOAD;
                        state_d  = ST_DELAY;
                    end
                end
                ST_DELAY, ST_REPEAT: begin
                    if (zone_q == ZONE_NEUTRAL) begin
                        state_d = ST_NEUTRAL;
                    end else if (want_dir != dir_q) begin
                        // Reversal restarts the full hold delay.
                        step_req = 1'b1;
                        dir_d    = want_dir;
                        cnt_d    = HOLD_RELOAD;
                        state_d  = ST_DELAY;
                    end else if (cnt_q == '0) begin
                        step_req = 1'b1;
                        cnt_d    = REPEAT_RELOAD;
                        state_d  = ST_REPEAT;
                    end else begin
                        cnt_d = cnt_q - 1'b1;
                    end
                end
                default: state_d = ST_NEUTRAL;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!clr) begin
            zone_q       <= ZONE_NEUTRAL;
            state_q      <= ST_NEUTRAL;
            cnt_q        <= '0;
            dir_q        <= 1'b0;
            plrpos_q     <= PLR_START;
            step_pulse_q <= 1'b0;
            step_dir_q   <= 1'b0;
        end else begin
            if (bus.pos_valid) begin
                if (pos_ext < LEFT_ENTER) begin
                    zone_q <= ZONE_LEFT;
                end else if (pos_ext > RIGHT_ENTER) begin
                    zone_q <= ZONE_RIGHT;
                end else if (pos_ext >= LEFT_EXIT && pos_ext <= RIGHT_EXIT) begin
                    zone_q <= ZONE_NEUTRAL;
                end
                // Otherwise inside a hysteresis band: zone holds.
            end

            state_q      <= state_d;
            cnt_q        <= cnt_d;
            dir_q        <= dir_d;
            step_pulse_q <= 1'b0;

            // Saturated steps leave plrpos/pulse/step_dir untouched.
            if (step_req) begin
                if (dir_d && plrpos_q != PLR_TOP) begin
                    plrpos_q     <= plrpos_q + 4'd1;
                    step_pulse_q <= 1'b1;
                    step_dir_q   <= 1'b1;
                end else if (!dir_d && plrpos_q != 4'd0) begin
                    plrpos_q     <= plrpos_q - 4'd1;
                    step_pulse_q <= 1'b1;
                    step_dir_q   <= 1'b0;
                end
            end
        end
    end

    assign bus.plrpos     = plrpos_q;
    assign bus.step_pulse = step_pulse_q;
    assign bus.step_dir   = step_dir_q;
    assign bus.zone       = zone_q;

endmodule
